// File: rtl/mux16to1_rr_arbiter_if.sv
// Bus bundle between the requester bank, the round-robin arbiter and the consumer of f.
interface mux16to1_rr_arbiter_if;
    logic [0:15] req;
    logic [0:15] w;
    logic        ready;
    logic [3:0]  s16;
    logic [0:15] grant;
    logic        valid;
    logic        f;

    // Requester/consumer side drives requests, data and ready.
    modport master (
        output req, w, ready,
        input  s16, grant, valid, f
    );

    // Arbiter side.
    modport slave (
        input  req, w, ready,
        output s16, grant, valid, f
    );
endinterface

// File: rtl/mux16to1_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 16:1 mux; a grant holds for
// at most MAX_HOLD accepted transfers before rotating to the next requester.
module mux16to1_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mux16to1_rr_arbiter_if.slave     bus
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned N_REQ = 16;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [IDX_W-1:0] sel, sel_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic [0:15]      grant_q, grant_nxt;

    logic [IDX_W-1:0] pick_base;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             pick_hit;
    logic [0:15]      pick_oh;

    logic             valid_c;
    logic             accept_c;
    logic             release_c;
    logic [IDX_W-1:0] cnt_inc;

    assign valid_c   = (state == GRANT) && bus.req[sel];
    assign accept_c  = valid_c && bus.ready;
    assign cnt_inc   = cnt + IDX_W'(1);
    assign release_c = !bus.req[sel] || (accept_c && (cnt_inc == IDX_W'(MAX_HOLD)));

    assign bus.valid = valid_c;
    assign bus.f     = valid_c & bus.w[sel];
    assign bus.s16   = sel;
    assign bus.grant = grant_q;

    // Circular search starting just past the base; the base itself is tried last.
    always_comb begin
        pick_base = (state == GRANT) ? sel : last;
        pick_idx  = pick_base;
        pick_hit  = 1'b0;
        cand      = '0;
        pick_oh   = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = pick_base + IDX_W'(i);
            if (!pick_hit && bus.req[cand]) begin
                pick_hit = 1'b1;
                pick_idx = cand;
            end
        end
        pick_oh[pick_idx] = 1'b1;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last;
        cnt_nxt   = cnt;
        grant_nxt = grant_q;
        case (state)
            IDLE: begin
                if (pick_hit) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_idx;
                    grant_nxt = pick_oh;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    last_nxt = sel;
                    cnt_nxt  = '0;
                    // Back-to-back handover when anyone is still asking.
                    if (pick_hit) begin
                        sel_nxt   = pick_idx;
                        grant_nxt = pick_oh;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (accept_c) begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            last    <= IDX_W'(15);
            cnt     <= '0;
            grant_q <= '0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            grant_q <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_mux16to1_rr_arbiter.sv
// Randomised and directed checks of the round-robin mux arbiter against a behavioural model.
module tb_mux16to1_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux16to1_rr_arbiter_if bus();

    mux16to1_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who holds the mux, who held it last, transfers so far.
    bit m_busy;
    int m_sel;
    int m_last;
    int m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int base, input logic [0:15] r);
        for (int k = 1; k <= 16; k++) begin
            if (r[(base + k) % 16]) return (base + k) % 16;
        end
        return base;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_last = 15;
        m_cnt  = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        logic [0:15] r;
        bit          acc;
        r = bus.req;
        if (!m_busy) begin
            if (r != 16'h0) begin
                m_busy = 1'b1;
                m_sel  = rr_pick(m_last, r);
                m_cnt  = 0;
            end
        end else begin
            acc = r[m_sel] && bus.ready;
            if (!r[m_sel] || (acc && m_cnt + 1 == MAX_HOLD)) begin
                m_last = m_sel;
                m_cnt  = 0;
                if (r != 16'h0) m_sel = rr_pick(m_last, r);
                else            m_busy = 1'b0;
            end else if (acc) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [0:15] eg;
        bit          ev;
        bit          ef;
        eg = '0;
        if (m_busy) eg[m_sel] = 1'b1;
        ev = m_busy && bus.req[m_sel];
        ef = ev && bus.w[m_sel];
        chk("s16",   32'(bus.s16),   32'(m_sel));
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("valid", 32'(bus.valid), 32'(ev));
        chk("f",     32'(bus.f),     32'(ef));
    endtask

    // One clock: apply inputs, compare on the falling edge, advance the model, step past the rising edge.
    task automatic step(input logic [0:15] r, input logic [0:15] wv, input logic rdy);
        bus.req   = r;
        bus.w     = wv;
        bus.ready = rdy;
        @(negedge clk);
        check_outputs();
        if (!rst) model_edge();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_s16",   32'(bus.s16),   32'h0);
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_f",     32'(bus.f),     32'h0);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [0:15] wpat;
    logic [0:15] r;
    logic [0:15] rr;

    initial begin
        wpat      = 16'b0101010101010101;
        rst       = 1'b1;
        bus.req   = 16'hFFFF;
        bus.w     = wpat;
        bus.ready = 1'b1;
        model_reset();
        #1;
        chk("init_grant", 32'(bus.grant), 32'h0);
        chk("init_valid", 32'(bus.valid), 32'h0);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full rotation 0..15,0 with 4-cycle grants and alternating data.
        for (int k = 0; k < 68; k++) begin
            step(16'hFFFF, wpat, 1'b1);
            chk("rot_s16",   32'(bus.s16),   32'((k / 4) % 16));
            chk("rot_valid", 32'(bus.valid), 32'h1);
            chk("rot_f",     32'(bus.f),     32'(((k / 4) % 16) % 2));
        end
        reset_pulse();
        step(16'hFFFF, wpat, 1'b1);
        chk("post_rst_s16", 32'(bus.s16), 32'h0);

        // Early release of 3 after two transfers, then 14, then back to 3.
        reset_pulse();
        r = '0; r[3] = 1'b1; r[14] = 1'b1;
        step(r, wpat, 1'b1);
        chk("er_first", 32'(bus.s16), 32'd3);
        step(r, wpat, 1'b1);
        step(r, wpat, 1'b1);
        chk("er_hold", 32'(bus.s16), 32'd3);
        r[3] = 1'b0;
        step(r, wpat, 1'b1);
        chk("er_wrap", 32'(bus.s16), 32'd14);
        r[3] = 1'b1;
        for (int k = 0; k < 4; k++) step(r, wpat, 1'b1);
        chk("er_back3", 32'(bus.s16), 32'd3);
        step(16'h0, wpat, 1'b1);
        chk("er_idle_grant", 32'(bus.grant), 32'h0);
        chk("er_idle_s16",   32'(bus.s16),   32'd3);

        // Back-pressure on a single requester, then handover after exactly 4 accepts.
        reset_pulse();
        r = '0; r[7] = 1'b1;
        step(r, wpat, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(r, wpat, 1'b0);
            chk("bp_s16",   32'(bus.s16),   32'd7);
            chk("bp_valid", 32'(bus.valid), 32'h1);
        end
        for (int k = 0; k < 4; k++) step(r, wpat, 1'b1);
        chk("bp_regrant", 32'(bus.s16), 32'd7);
        r[2] = 1'b1;
        for (int k = 0; k < 3; k++) step(r, wpat, 1'b1);
        chk("bp_still7", 32'(bus.s16), 32'd7);
        step(r, wpat, 1'b1);
        chk("bp_to2", 32'(bus.s16), 32'd2);

        // Reset mid-grant: the search restarts from index 0 with a fresh allotment.
        reset_pulse();
        r = '0; r[9] = 1'b1;
        for (int k = 0; k < 3; k++) step(r, wpat, 1'b1);
        reset_pulse();
        r[10] = 1'b1;
        step(r, wpat, 1'b1);
        chk("mg_first", 32'(bus.s16), 32'd9);
        for (int k = 0; k < 3; k++) step(r, wpat, 1'b1);
        chk("mg_full", 32'(bus.s16), 32'd9);
        step(r, wpat, 1'b1);
        chk("mg_next", 32'(bus.s16), 32'd10);

        // Random traffic with sticky requests, random data and ready.
        rr = '0;
        for (int k = 0; k < 800; k++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(7) == 0) rr[b] = ~rr[b];
            end
            if (k % 150 == 149) reset_pulse();
            step(rr, 16'($urandom), ($urandom_range(3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
